// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ----------------
// Hazard detection and operand-forwarding control for a classic 5-stage
// pipeline. A small shadow copy of the EX, MEM and WB slots (valid, rd,
// reg_write, mem_read) is used to decide whether the instruction in ID may
// enter EX. The unit also registers the ALU operand-mux selects that go with
// that instruction.
//
// Build option:
//   HAZARD_FWD_EN defined   : full forwarding. A stall is raised only for a
//                             load-use hazard (one cycle). The selects are
//                             10 = EX/MEM, 01 = MEM/WB, 00 = regfile.
//   HAZARD_FWD_EN undefined : no forwarding. The selects stay at 00, and ID
//                             stalls while any EX or MEM producer matches.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs / id_rt     ID source registers; id_use_rs / id_use_rt qualify them
//   id_rd             ID destination; id_reg_write / id_mem_read qualify it
//   flush             branch taken: discard the ID instruction
//   stall             combinational: hold PC and IF/ID, inject a bubble
//   ex_fwd_a/b        registered operand-mux selects for the EX instruction
//   ex_bubble         EX slot holds no valid instruction
//   stall_cnt         saturating count of stall cycles
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  ex_fwd_a,
  output logic [1:0]  ex_fwd_b,
  output logic        ex_bubble,
  output logic [15:0] stall_cnt
);

  // Pipeline slot shadow state
  logic       ex_valid_reg, mem_valid_reg, wb_valid_reg;
  logic [4:0] ex_rd_reg, mem_rd_reg, wb_rd_reg;
  logic       ex_rw_reg, mem_rw_reg, wb_rw_reg;
  logic       ex_mr_reg, mem_mr_reg, wb_mr_reg;
  logic [15:0] stall_cnt_reg;

  // Index 0 = rs (operand A), index 1 = rt (operand B)
  logic [4:0] src [2];
  logic [1:0] use_src;
  logic [1:0] ex_hit;
  logic [1:0] mem_hit;
  logic       load_ex;

  assign src[0]  = id_rs;
  assign src[1]  = id_rt;
  assign use_src = {id_use_rt, id_use_rs};

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi]  = ex_valid_reg & ex_rw_reg & (ex_rd_reg == src[gi]) &
                           (ex_rd_reg != 5'd0) & use_src[gi];
      assign mem_hit[gi] = mem_valid_reg & mem_rw_reg & (mem_rd_reg == src[gi]) &
                           (mem_rd_reg != 5'd0) & use_src[gi];
    end
  endgenerate

  // WB matches never matter: the register file writes through, so ID
  // reads the value the WB stage is writing back.
`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot forward in time. One cycle later it
  // sits in MEM, and the MEM/WB path covers it.
  assign stall = rst_n & id_valid & ~flush & ex_mr_reg & (|ex_hit);
`else
  // With no bypass paths, wait until the producer has reached WB.
  assign stall = rst_n & id_valid & ~flush & ((|ex_hit) | (|mem_hit));
`endif

  assign load_ex = id_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_reg  <= 1'b0;
      ex_rd_reg     <= 5'd0;
      ex_rw_reg     <= 1'b0;
      ex_mr_reg     <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_rd_reg    <= 5'd0;
      mem_rw_reg    <= 1'b0;
      mem_mr_reg    <= 1'b0;
      wb_valid_reg  <= 1'b0;
      wb_rd_reg     <= 5'd0;
      wb_rw_reg     <= 1'b0;
      wb_mr_reg     <= 1'b0;
      stall_cnt_reg <= 16'd0;
    end else begin
      wb_valid_reg  <= mem_valid_reg;
      wb_rd_reg     <= mem_rd_reg;
      wb_rw_reg     <= mem_rw_reg;
      wb_mr_reg     <= mem_mr_reg;
      mem_valid_reg <= ex_valid_reg;
      mem_rd_reg    <= ex_rd_reg;
      mem_rw_reg    <= ex_rw_reg;
      mem_mr_reg    <= ex_mr_reg;
      ex_valid_reg  <= load_ex;
      ex_rd_reg     <= load_ex ? id_rd : 5'd0;
      ex_rw_reg     <= load_ex & id_reg_write;
      ex_mr_reg     <= load_ex & id_mem_read;
      if (stall && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_next [2];
  logic [1:0] fwd_reg  [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // The newest producer (EX) wins over the older one (MEM).
      assign fwd_next[gi] = ex_hit[gi]  ? 2'b10 :
                            mem_hit[gi] ? 2'b01 : 2'b00;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          fwd_reg[gi] <= 2'b00;
        end else begin
          fwd_reg[gi] <= load_ex ? fwd_next[gi] : 2'b00;
        end
      end
    end
  endgenerate

  assign ex_fwd_a = fwd_reg[0];
  assign ex_fwd_b = fwd_reg[1];
`else
  assign ex_fwd_a = 2'b00;
  assign ex_fwd_b = 2'b00;
`endif

  assign ex_bubble = ~ex_valid_reg;
  assign stall_cnt = stall_cnt_reg;

  // The WB slot is kept for pipeline visibility only, and mem_read is not
  // needed past EX. This collects the bits that nothing else reads.
  logic unused_ok;
  assign unused_ok = ^{wb_valid_reg, wb_rd_reg, wb_rw_reg, wb_mr_reg,
                       mem_mr_reg, ex_mr_reg};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. It works in both builds: the expected
// values are chosen from HAZARD_FWD_EN.
module tb_hazard_fwd_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read, flush;
  logic        stall;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic        ex_bubble;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  int n;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input logic [4:0] rd,
                        input bit rw, input bit mr, input bit fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
  endtask

  task automatic idle(input int k);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (k) tick();
  endtask

  // Count stall cycles while the ID instruction is held (bounded).
  task automatic wait_stalls(output int cnt);
    cnt = 0;
    while (stall === 1'b1 && cnt < 6) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    set_id(1, 3, 3, 1, 1, 4, 1, 1, 0);
    chk("rst_stall", 16'(stall), 16'd0);
    tick(); tick();
    chk("rst_fwd_a", 16'(ex_fwd_a), 16'd0);
    chk("rst_fwd_b", 16'(ex_fwd_b), 16'd0);
    chk("rst_bubble", 16'(ex_bubble), 16'd1);
    chk("rst_cnt", stall_cnt, 16'd0);
    rst_n = 1'b1;
    idle(1);
    $display("[TB] reset checked");

    // S1: add r3,r1,r2 ; sub r4,r3,r5
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); wait_stalls(n);
    chk("s1_prod_stalls", 16'(n), 16'd0); tick();
    set_id(1, 3, 5, 1, 1, 4, 1, 0, 0); wait_stalls(n);
    chk("s1_cons_stalls", 16'(n), FWD ? 16'd0 : 16'd2); exp_cnt += n; tick();
    chk("s1_fwd_a", 16'(ex_fwd_a), FWD ? 16'd2 : 16'd0);
    chk("s1_fwd_b", 16'(ex_fwd_b), 16'd0);
    chk("s1_bubble", 16'(ex_bubble), 16'd0);
    chk("s1_cnt", stall_cnt, 16'(exp_cnt));
    $display("[TB] dep pair: stalls=%0d fwd_a=%0d cnt=%0d", n, ex_fwd_a, stall_cnt);
    idle(3);

    // S2: add r3 ; nop ; or r6,r3,r3
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 3, 3, 1, 1, 6, 1, 0, 0); wait_stalls(n);
    chk("s2_stalls", 16'(n), FWD ? 16'd0 : 16'd1); exp_cnt += n; tick();
    chk("s2_fwd_a", 16'(ex_fwd_a), FWD ? 16'd1 : 16'd0);
    chk("s2_fwd_b", 16'(ex_fwd_b), FWD ? 16'd1 : 16'd0);
    $display("[TB] dist2: stalls=%0d fwd_a=%0d fwd_b=%0d", n, ex_fwd_a, ex_fwd_b);
    idle(3);

    // S3: lw r8 ; add r9,r8,r8
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 0); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("s3_stall", 16'(stall), 16'd1); tick();
    chk("s3_bubble", 16'(ex_bubble), 16'd1);
    wait_stalls(n);
    chk("s3_extra_stalls", 16'(n), FWD ? 16'd0 : 16'd1); exp_cnt += 1 + n; tick();
    chk("s3_fwd_a", 16'(ex_fwd_a), FWD ? 16'd1 : 16'd0);
    chk("s3_fwd_b", 16'(ex_fwd_b), FWD ? 16'd1 : 16'd0);
    chk("s3_cnt", stall_cnt, 16'(exp_cnt));
    $display("[TB] load-use: extra=%0d fwd_a=%0d cnt=%0d", n, ex_fwd_a, stall_cnt);
    idle(3);

    // S4: addi r0 ; use r0
    set_id(1, 1, 0, 1, 0, 0, 1, 0, 0); tick();
    set_id(1, 0, 0, 1, 1, 10, 1, 0, 0); wait_stalls(n);
    chk("s4_stalls", 16'(n), 16'd0); tick();
    chk("s4_fwd_a", 16'(ex_fwd_a), 16'd0);
    chk("s4_fwd_b", 16'(ex_fwd_b), 16'd0);
    $display("[TB] r0: stalls=%0d fwd_a=%0d fwd_b=%0d", n, ex_fwd_a, ex_fwd_b);
    idle(3);

    // S5: add r3 ; sub r3,r1,r2 ; consumer r3,r3
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); wait_stalls(n);
    chk("s5_mid_stalls", 16'(n), 16'd0); tick();
    set_id(1, 3, 3, 1, 1, 11, 1, 0, 0); wait_stalls(n);
    chk("s5_stalls", 16'(n), FWD ? 16'd0 : 16'd2); exp_cnt += n; tick();
    chk("s5_fwd_a", 16'(ex_fwd_a), FWD ? 16'd2 : 16'd0);
    chk("s5_fwd_b", 16'(ex_fwd_b), FWD ? 16'd2 : 16'd0);
    $display("[TB] double producer: stalls=%0d fwd_a=%0d", n, ex_fwd_a);
    idle(3);

    // S6: flush during load-use, then reset mid-stall
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 0); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0, 1);
    chk("s6_flush_stall", 16'(stall), 16'd0); tick();
    chk("s6_flush_bubble", 16'(ex_bubble), 16'd1);
    chk("s6_flush_fwd_a", 16'(ex_fwd_a), 16'd0);
    $display("[TB] flush: stall=%0d bubble=%0d", stall, ex_bubble);
    idle(3);
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 0); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("s6_pre_rst_stall", 16'(stall), 16'd1);
    chk("s6_pre_rst_cnt", stall_cnt, 16'(exp_cnt));
    rst_n = 1'b0; #1;
    chk("s6_rst_stall_comb", 16'(stall), 16'd0);
    tick();
    chk("s6_rst_stall", 16'(stall), 16'd0);
    chk("s6_rst_bubble", 16'(ex_bubble), 16'd1);
    chk("s6_rst_fwd_a", 16'(ex_fwd_a), 16'd0);
    chk("s6_rst_fwd_b", 16'(ex_fwd_b), 16'd0);
    chk("s6_rst_cnt", stall_cnt, 16'd0);
    rst_n = 1'b1; #1;
    chk("s6_post_rst_stall", 16'(stall), 16'd0);
    tick();
    chk("s6_post_rst_bubble", 16'(ex_bubble), 16'd0);
    chk("s6_post_rst_fwd_a", 16'(ex_fwd_a), 16'd0);
    $display("[TB] reset mid-stall: stall=%0d cnt=%0d", stall, stall_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL provide ports as listed; clk and rst_n first.
- clk, input, 1, single clock; all state changes on rising edge.
- rst_n, input, 1, reset; synchronous and active-low.
- id_valid, input, 1, ID stage holds a real instruction.
- id_rs, input, 5, ID source register A.
- id_rt, input, 5, ID source register B.
- id_use_rs, input, 1, instruction reads rs.
- id_use_rt, input, 1, instruction reads rt.
- id_rd, input, 5, ID destination register.
- id_reg_write, input, 1, instruction writes id_rd.
- id_mem_read, input, 1, instruction is a load.
- flush, input, 1, branch taken; discard the ID instruction.
- stall, output, 1, combinational; hold PC and IF/ID, inject bubble.
- ex_fwd_a, output, 2, registered select for the ALU operand A mux: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- ex_fwd_b, output, 2, same encoding for operand B.
- ex_bubble, output, 1, registered; EX holds no valid instruction.
- stall_cnt, output, 16, registered count of stall cycles.

Function
REQ-002 SHALL track three slots (EX, MEM, WB). Each slot holds valid, rd, reg_write and mem_read.
REQ-003 Every non-reset cycle SHALL shift the slots: WB<=MEM, MEM<=EX.
REQ-004 EX SHALL load the ID fields when id_valid=1 and stall=0 and flush=0. Otherwise EX SHALL load a bubble (valid=0, reg_write=0, mem_read=0).
REQ-005 A slot "matches" source s only when all hold: valid=1, reg_write=1, rd==s, rd!=0, and the matching id_use_* bit is 1.
REQ-006 Register 0 SHALL never cause a stall or a forward.
REQ-007 ex_fwd_a and ex_fwd_b SHALL be registered when the ID instruction enters EX, using these priorities:
- 10 if the current EX slot matches;
- else 01 if the current MEM slot matches;
- else 00.
REQ-008 The newest producer SHALL win when both EX and MEM match.
REQ-009 ex_fwd_a and ex_fwd_b SHALL be 00 whenever a bubble enters EX.
REQ-010 A WB-slot match SHALL need no forward or stall, because the register file is write-through.
REQ-011 Load-use: stall SHALL be 1 when id_valid=1, flush=0, and the EX slot has mem_read=1 and matches rs or rt.
REQ-012 A load-use stall SHALL last exactly one cycle. The next cycle the load sits in MEM and the consumer receives 01.
REQ-013 flush SHALL have priority over stall: when flush=1, stall=0 and a bubble enters EX.
REQ-014 ex_bubble SHALL equal the inverse of the EX slot valid bit.
REQ-015 stall_cnt SHALL increment on each cycle with stall=1 and SHALL saturate at 16'hFFFF.
REQ-016 Latency: forward selects SHALL be valid in the same cycle the instruction occupies EX (one cycle after ID).

Reset
REQ-017 While rst_n=0 at a clock edge, all slots SHALL become bubbles, with ex_fwd_a=00, ex_fwd_b=00, ex_bubble=1 and stall_cnt=0.
REQ-018 stall SHALL be 0 during reset.
REQ-019 Reset asserted mid-stall SHALL drop the stall on the next edge, with no leftover hazard state.

Configuration
REQ-020 Macro HAZARD_FWD_EN SHALL select forwarding behaviour.
REQ-021 With HAZARD_FWD_EN defined, REQ-007 to REQ-012 apply.
REQ-022 Without HAZARD_FWD_EN:
- ex_fwd_a and ex_fwd_b SHALL be constant 00;
- stall SHALL assert whenever the EX or MEM slot matches rs or rt, regardless of mem_read;
- stall SHALL hold until the producer reaches WB.
A dependent ALU pair therefore incurs 2 stall cycles.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Dependent ALU pair: add r3,r1,r2 then sub r4,r3,r5. Consumer in EX shall see ex_fwd_a=10 and stall never asserts. Without the macro, stall=1 for 2 cycles and stall_cnt=2.
- Distance-2 dependency: add r3; unrelated nop-class op; or r6,r3,r3. Consumer shall get ex_fwd_a=01 and ex_fwd_b=01.
- Load-use: lw r8 then add r9,r8,r8. stall=1 for exactly 1 cycle, ex_bubble=1 in the following cycle, then ex_fwd_a=ex_fwd_b=01, and stall_cnt=1.
- r0 destination: addi r0 then use r0. No stall, and forward selects stay 00.
- Double producer: add r3 followed by sub r3, then consumer of r3. The consumer shall get 10, from the newest producer.
- flush=1 coincident with a load-use condition: stall=0 and ex_bubble=1 next cycle. Then assert rst_n=0 during a stall: all outputs return to their reset values.
